// File: rtl/mmio_xbar_nslv_pkg.sv
// Shared definitions for the MMIO crossbar: bus widths, FSM state encoding
// and the data word returned when a read is aborted.
package mmio_xbar_nslv_pkg;

  localparam int ADDR_W = 30;
  localparam int DATA_W = 32;
  localparam int MASK_W = 4;

  localparam logic [DATA_W-1:0] MMIO_RD_TIMEOUT_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/mmio_xbar_nslv_if.sv
// Bundle of the CPU load/store port and the shared slave-side bus of the
// crossbar; the crossbar uses the slave view, the CPU/peripheral side the master view.
interface mmio_xbar_nslv_if
  import mmio_xbar_nslv_pkg::*;
#(
  parameter int N_SLV = 4
);

  logic [ADDR_W-1:0]       mmio_addr;
  logic [DATA_W-1:0]       mmio_wdata;
  logic [MASK_W-1:0]       mmio_mask;
  logic                    mmio_wren;
  logic                    mmio_rden;
  logic [DATA_W-1:0]       mmio_rdata;
  logic                    mmio_stall;

  logic [ADDR_W-1:0]       slv_addr;
  logic [DATA_W-1:0]       slv_data;
  logic [MASK_W-1:0]       slv_mask;
  logic [N_SLV-1:0]        slv_wren;
  logic [N_SLV-1:0]        slv_rden;
  logic [N_SLV*DATA_W-1:0] slv_rdata;
  logic [N_SLV-1:0]        slv_rvalid;

  logic                    err;

  modport slave (
    input  mmio_addr, mmio_wdata, mmio_mask, mmio_wren, mmio_rden,
    output mmio_rdata, mmio_stall,
    output slv_addr, slv_data, slv_mask, slv_wren, slv_rden,
    input  slv_rdata, slv_rvalid,
    output err
  );

  modport master (
    output mmio_addr, mmio_wdata, mmio_mask, mmio_wren, mmio_rden,
    input  mmio_rdata, mmio_stall,
    input  slv_addr, slv_data, slv_mask, slv_wren, slv_rden,
    output slv_rdata, slv_rvalid,
    input  err
  );

endinterface

// File: rtl/mmio_xbar_nslv_addr_decode.sv
// Combinational base/mask address decoder; the lowest-indexed matching
// slave wins, and no match at all reports a miss (hit=0, sel=0).
module mmio_xbar_nslv_addr_decode
  import mmio_xbar_nslv_pkg::*;
#(
  parameter int                        N_SLV = 4,
  parameter logic [N_SLV*ADDR_W-1:0]   BASE  = {N_SLV{30'h0}},
  parameter logic [N_SLV*ADDR_W-1:0]   AMASK = {N_SLV{30'h3FFF_FFFF}}
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [N_SLV-1:0]  sel,
  output logic              hit
);

  // Scan from the top so the lowest matching index is the last one written.
  always_comb begin
    sel = '0;
    hit = 1'b0;
    for (int i = N_SLV - 1; i >= 0; i--) begin
      if ((addr & AMASK[ADDR_W*i +: ADDR_W]) == BASE[ADDR_W*i +: ADDR_W]) begin
        sel    = '0;
        sel[i] = 1'b1;
        hit    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mmio_xbar_nslv.sv
// MMIO crossbar: stalls the CPU for one access at a time, issues a one-cycle
// strobe to the decoded slave, waits for read data with a timeout, flags errors.
module mmio_xbar_nslv
  import mmio_xbar_nslv_pkg::*;
#(
  parameter int                        N_SLV   = 4,
  parameter logic [N_SLV*ADDR_W-1:0]   BASE    = {N_SLV{30'h0}},
  parameter logic [N_SLV*ADDR_W-1:0]   AMASK   = {N_SLV{30'h3FFF_FFFF}},
  parameter int                        TIMEOUT = 15
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  mmio_xbar_nslv_if.slave        bus
);

  localparam int              CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e              state;
  logic                wr_q;
  logic                hit_q;
  logic [N_SLV-1:0]    sel_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic [MASK_W-1:0]   mask_q;
  logic [N_SLV-1:0]    wren_q;
  logic [N_SLV-1:0]    rden_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                err_q;

  logic [N_SLV-1:0]    dec_sel;
  logic                dec_hit;
  logic                rsel_vld;
  logic [DATA_W-1:0]   rsel_data;
  logic                req;

  mmio_xbar_nslv_addr_decode #(
    .N_SLV (N_SLV),
    .BASE  (BASE),
    .AMASK (AMASK)
  ) u_decode (
    .addr (bus.mmio_addr),
    .sel  (dec_sel),
    .hit  (dec_hit)
  );

  assign req = bus.mmio_wren | bus.mmio_rden;

  // Only the selected slave's rvalid/rdata are visible to the FSM.
  always_comb begin
    rsel_vld  = |(bus.slv_rvalid & sel_q);
    rsel_data = '0;
    for (int i = 0; i < N_SLV; i++) begin
      if (sel_q[i]) rsel_data = rsel_data | bus.slv_rdata[DATA_W*i +: DATA_W];
    end
  end

  always_comb begin
    case (state)
      ST_IDLE: bus.mmio_stall = req;
      ST_DONE: bus.mmio_stall = 1'b0;
      default: bus.mmio_stall = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= ST_IDLE;
      wr_q    <= 1'b0;
      hit_q   <= 1'b0;
      sel_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      mask_q  <= '0;
      wren_q  <= '0;
      rden_q  <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      wren_q <= '0;
      rden_q <= '0;
      case (state)
        ST_IDLE: begin
          if (req) begin
            addr_q  <= bus.mmio_addr;
            data_q  <= bus.mmio_wdata;
            mask_q  <= bus.mmio_mask;
            wr_q    <= bus.mmio_wren;
            sel_q   <= dec_sel;
            hit_q   <= dec_hit;
            rdata_q <= '0;
            // Strobe is registered here so it is visible during ISSUE; a
            // simultaneous read+write request is handled as a write.
            if (bus.mmio_wren) wren_q <= dec_sel;
            else               rden_q <= dec_sel;
            state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          cnt_q <= '0;
          if (!hit_q) begin
            err_q <= 1'b1;
            state <= ST_DONE;
          end else if (wr_q) begin
            state <= ST_DONE;
          end else begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (rsel_vld) begin
            rdata_q <= rsel_data;
            state   <= ST_DONE;
          end else if (cnt_q == CNT_LAST) begin
            rdata_q <= MMIO_RD_TIMEOUT_DATA;
            err_q   <= 1'b1;
            state   <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.slv_addr   = addr_q;
  assign bus.slv_data   = data_q;
  assign bus.slv_mask   = mask_q;
  assign bus.slv_wren   = wren_q;
  assign bus.slv_rden   = rden_q;
  assign bus.mmio_rdata = rdata_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_mmio_xbar_nslv.sv
// Directed bench for mmio_xbar_nslv: a transaction-level model turns each
// access into per-cycle expectations that one compare process checks.
module tb_mmio_xbar_nslv;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [29:0] t_addr = '0;
  logic [31:0] t_wdata = '0;
  logic [3:0]  t_mask = '0;
  logic        t_wren = 1'b0;
  logic        t_rden = 1'b0;
  logic [1:0]  t_rvalid = '0;
  logic [63:0] t_rdata = '0;
  bit          use_ov = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mmio_xbar_nslv_if #(.N_SLV(2)) b0 ();
  mmio_xbar_nslv_if #(.N_SLV(2)) b1 ();

  assign b0.mmio_addr  = t_addr;   assign b1.mmio_addr  = t_addr;
  assign b0.mmio_wdata = t_wdata;  assign b1.mmio_wdata = t_wdata;
  assign b0.mmio_mask  = t_mask;   assign b1.mmio_mask  = t_mask;
  assign b0.mmio_wren  = t_wren;   assign b1.mmio_wren  = t_wren;
  assign b0.mmio_rden  = t_rden;   assign b1.mmio_rden  = t_rden;
  assign b0.slv_rvalid = t_rvalid; assign b1.slv_rvalid = t_rvalid;
  assign b0.slv_rdata  = t_rdata;  assign b1.slv_rdata  = t_rdata;

  mmio_xbar_nslv #(
    .N_SLV(2), .BASE({30'h200, 30'h100}), .AMASK({2{30'h3FFF_FF00}}), .TIMEOUT(TMO)
  ) dut0 (.i_clk(clk), .i_rst_n(rst_n), .bus(b0));

  // Second instance with overlapping windows (both slaves at 30'h100).
  mmio_xbar_nslv #(
    .N_SLV(2), .BASE({30'h100, 30'h100}), .AMASK({2{30'h3FFF_FF00}}), .TIMEOUT(TMO)
  ) dut1 (.i_clk(clk), .i_rst_n(rst_n), .bus(b1));

  logic        m_stall, m_err;
  logic [31:0] m_rdata, m_sdata;
  logic [29:0] m_saddr;
  logic [3:0]  m_smask;
  logic [1:0]  m_wren, m_rden;
  assign m_stall = use_ov ? b1.mmio_stall : b0.mmio_stall;
  assign m_err   = use_ov ? b1.err        : b0.err;
  assign m_rdata = use_ov ? b1.mmio_rdata : b0.mmio_rdata;
  assign m_sdata = use_ov ? b1.slv_data   : b0.slv_data;
  assign m_saddr = use_ov ? b1.slv_addr   : b0.slv_addr;
  assign m_smask = use_ov ? b1.slv_mask   : b0.slv_mask;
  assign m_wren  = use_ov ? b1.slv_wren   : b0.slv_wren;
  assign m_rden  = use_ov ? b1.slv_rden   : b0.slv_rden;

  typedef struct {
    bit          stall;
    logic [1:0]  wren;
    logic [1:0]  rden;
    bit          chk_data;
    logic [31:0] data;
    bit          err;
    bit          chk_lat;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
  } exp_t;

  exp_t exp_q[$];
  bit   model_err = 1'b0;

  int          stall_hi;
  int          wren_pulses;
  logic [1:0]  rden_seen;
  logic [31:0] last_data;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("stall", 32'(m_stall), 32'(e.stall));
      chk("slv_wren", 32'(m_wren), 32'(e.wren));
      chk("slv_rden", 32'(m_rden), 32'(e.rden));
      chk("err", 32'(m_err), 32'(e.err));
      if (e.chk_lat) begin
        chk("slv_addr", 32'(m_saddr), 32'(e.addr));
        chk("slv_data", m_sdata, e.wdata);
        chk("slv_mask", 32'(m_smask), 32'(e.mask));
      end
      if (e.chk_data) begin
        chk("mmio_rdata", m_rdata, e.data);
        last_data = m_rdata;
      end
      if (m_stall) stall_hi++;
      if (|m_wren) wren_pulses++;
      rden_seen = rden_seen | m_rden;
    end
  end

  function automatic int model_sel(input logic [29:0] a);
    logic [29:0] base [2];
    base[0] = 30'h100;
    base[1] = use_ov ? 30'h100 : 30'h200;
    for (int i = 0; i < 2; i++)
      if ((a & 30'h3FFF_FF00) == base[i]) return i;
    return -1;
  endfunction

  // rc0/rc1: cycle (counted from the request cycle) on which slave 0/1 pulses
  // rvalid; -1 means that slave never answers.
  task automatic xact(input bit wr, input bit rd, input logic [29:0] a,
                      input logic [31:0] d, input logic [3:0] m,
                      input int rc0, input logic [31:0] rd0,
                      input int rc1, input logic [31:0] rd1);
    int          sel, n, w, rc;
    bit          err_set;
    logic [31:0] res;
    exp_t        e;
    sel = model_sel(a);
    if (wr || sel < 0) begin
      n = 3; res = '0; err_set = (sel < 0);
    end else begin
      rc = (sel == 0) ? rc0 : rc1;
      if (rc >= 2 && rc <= TMO + 1) begin
        w = rc - 1; res = (sel == 0) ? rd0 : rd1; err_set = 1'b0;
      end else begin
        w = TMO; res = 32'hDEAD_BEEF; err_set = 1'b1;
      end
      n = 3 + w;
    end
    stall_hi = 0; wren_pulses = 0; rden_seen = '0;
    for (int c = 0; c < n; c++) begin
      e.stall    = (c < n - 1);
      e.wren     = (c == 1 && sel >= 0 && wr)  ? 2'(1 << sel) : 2'b00;
      e.rden     = (c == 1 && sel >= 0 && !wr) ? 2'(1 << sel) : 2'b00;
      e.chk_data = (c == n - 1);
      e.data     = res;
      e.err      = model_err | (err_set && c == n - 1);
      e.chk_lat  = (c >= 1);
      e.addr     = a;
      e.wdata    = d;
      e.mask     = m;
      exp_q.push_back(e);
    end
    model_err = model_err | err_set;
    t_addr = a; t_wdata = d; t_mask = m; t_wren = wr; t_rden = rd;
    for (int c = 0; c < n; c++) begin
      t_rvalid = {(rc1 == c), (rc0 == c)};
      t_rdata  = {rd1, rd0};
      @(posedge clk); #1;
    end
    t_wren = 1'b0; t_rden = 1'b0; t_rvalid = '0;
  endtask

  task automatic idle(input int n);
    exp_t e;
    for (int c = 0; c < n; c++) begin
      e.stall = 1'b0; e.wren = '0; e.rden = '0; e.chk_data = 1'b0; e.data = '0;
      e.err = model_err; e.chk_lat = 1'b0; e.addr = '0; e.wdata = '0; e.mask = '0;
      exp_q.push_back(e);
      @(posedge clk); #1;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stall"}, 32'(b0.mmio_stall), 32'd0);
    chk({tag, "_wren"},  32'(b0.slv_wren), 32'd0);
    chk({tag, "_rden"},  32'(b0.slv_rden), 32'd0);
    chk({tag, "_rdata"}, b0.mmio_rdata, 32'd0);
    chk({tag, "_err"},   32'(b0.err), 32'd0);
    chk({tag, "_addr"},  32'(b0.slv_addr), 32'd0);
    chk({tag, "_data"},  b0.slv_data, 32'd0);
    chk({tag, "_mask"},  32'(b0.slv_mask), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Overlapping windows: slave 0 wins, slave 1's early rvalid is ignored.
    use_ov = 1'b1;
    idle(1);
    xact(1'b0, 1'b1, 30'h100, 32'h0, 4'hF, 3, 32'h2, 2, 32'h1);
    chk("t5_data", last_data, 32'h0000_0002);
    chk("t5_rden_seen", 32'(rden_seen), 32'h1);
    idle(1);

    use_ov = 1'b0;
    idle(1);
    xact(1'b1, 1'b0, 30'h104, 32'h0000_1234, 4'b0011, -1, '0, -1, '0);
    chk("t1_stall_cycles", stall_hi, 2);
    chk("t1_wren_pulses", wren_pulses, 1);
    xact(1'b0, 1'b1, 30'h208, 32'h0, 4'hF, -1, '0, 3, 32'hCAFE_F00D);
    chk("t2_data", last_data, 32'hCAFE_F00D);
    chk("t2_stall_cycles", stall_hi, 4);
    chk("t2_rden_seen", 32'(rden_seen), 32'h2);
    idle(2);
    xact(1'b1, 1'b0, 30'h2FC, 32'hA5A5_5A5A, 4'b0000, -1, '0, -1, '0);
    chk("mask0_wren_pulses", wren_pulses, 1);
    xact(1'b1, 1'b1, 30'h1F0, 32'h1111_2222, 4'b1000, -1, '0, 2, 32'h3);
    chk("wr_rd_rden_seen", 32'(rden_seen), 32'h0);
    xact(1'b0, 1'b1, 30'h108, 32'h0, 4'hF, 5, 32'h55AA_7788, -1, '0);
    chk("last_cycle_rvalid_data", last_data, 32'h55AA_7788);
    chk("last_cycle_rvalid_err", 32'(b0.err), 32'h0);
    xact(1'b0, 1'b1, 30'h208, 32'h0, 4'hF, -1, '0, -1, '0);
    chk("t3_data", last_data, 32'hDEAD_BEEF);
    chk("t3_stall_cycles", stall_hi, 6);
    chk("t3_err", 32'(b0.err), 32'h1);
    idle(1);
    xact(1'b1, 1'b0, 30'h300, 32'hFFFF_FFFF, 4'hF, -1, '0, -1, '0);
    chk("t4_wren_pulses", wren_pulses, 0);
    chk("t4_err", 32'(b0.err), 32'h1);
    idle(2);

    // Reset asserted while a read sits in WAIT.
    t_addr = 30'h208; t_rden = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0; t_rden = 1'b0;
    model_err = 1'b0;
    #1;
    chk_all_zero("t6_reset");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    idle(4);
    chk("t6_no_stray_wren", wren_pulses, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
